spi_byte_engine: RTL
====================

# spi_byte_engine

Byte-wide SPI master (mode 0, MSB first) that executes one full-duplex 8-bit transfer per write command for the SD card controller. It sits directly downstream of the SD card command sequencer, which drives it with single-cycle write and read strobes. It owns the physical SCK and MOSI pins, samples MISO, and selects between a slow init clock and programmable fast clocks. Chip select is not handled here; it stays with the sequencer.

## Interface
- FREQ, 48_000_000: system clock frequency in Hz.
- SLOW_HZ, 400_000: target SCK frequency when I_speed = 0.
- I_clk  in  1  system clock; all logic is on the rising edge.
- I_rst  in  1  synchronous, active-high reset.
- O_sck  out  1  SPI clock; idles low.
- O_mosi  out  1  SPI data out; idles high.
- I_miso  in  1  SPI data in.
- I_cmd_write  in  1  single-cycle strobe; starts a transfer of I_data_out.
- I_cmd_read  in  1  single-cycle strobe; acknowledges and clears O_data_ready.
- I_speed  in  4  SCK divider select.
- I_data_out  in  8  byte to transmit.
- O_data_in  out  8  last received byte.
- O_busy_write  out  1  transfer in progress.
- O_data_ready  out  1  O_data_in holds an unacknowledged byte.

## Operation
- Half-period H, in system clocks, is latched when a transfer is accepted.
  - I_speed = 0: H = FREQ/(2*SLOW_HZ), integer division, minimum 1. At the defaults H = 60 (400 kHz).
  - I_speed = n, 1..15: H = n.
- Changing I_speed mid-transfer has no effect on the current byte.
- States:
  - IDLE: SCK = 0, MOSI = 1, busy = 0.
  - XFER: 16 phases of H cycles each, alternating LOW and HIGH, starting with LOW.
- IDLE → XFER: on an edge where I_cmd_write = 1 and busy = 0.
  - Load the shift register with I_data_out.
  - MOSI = bit 7.
  - Phase counter = 0, divider = H-1.
  - Busy = 1.
- In XFER, the divider counts down. At 0 it reloads H-1 and toggles the phase.
  - LOW→HIGH: SCK ← 1; I_miso shifts into rx bit 0 (rx shifts left); the sample is taken on that clock edge.
  - HIGH→LOW, not the last phase: SCK ← 0; MOSI ← next tx bit.
  - HIGH→LOW, end of the 16th phase: SCK ← 0; MOSI ← 1; O_data_in ← rx byte; O_data_ready ← 1; busy ← 0; state ← IDLE.
- Write strobes while busy = 1 are ignored: no queueing and no error flag.
- O_data_ready is cleared by I_cmd_read when it is 1. A read strobe with ready = 0 is a no-op.
- Completion and I_cmd_read on the same edge: completion wins. Ready stays 1 with the new byte.
- A completion while ready is already 1 overwrites O_data_in. Ready stays 1.
- Write and read strobes on the same edge in IDLE are both honoured.
- Reset (any time, including mid-transfer):
  - O_sck = 0, O_mosi = 1, O_busy_write = 0, O_data_ready = 0, O_data_in = 0.
  - Divider, phase counter and shift registers are cleared. The state goes to IDLE.
  - A write strobe on the reset edge is dropped.

## Timing
- O_busy_write rises on the edge that samples I_cmd_write. It is therefore visible the cycle after the strobe, so a sequencer that gates on "!strobe && !busy" never double-issues.
- Busy stays high for exactly 16*H cycles.
- O_data_ready rises on the same edge that busy falls. A new write may be accepted on that edge's following cycle.
- First SCK rising edge: H cycles after acceptance. Last SCK falling edge: 16*H cycles after acceptance.
- MOSI is stable for at least H cycles before each SCK rising edge.
- Throughput: one byte per 16*H+1 cycles with back-to-back strobes.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Loopback (I_miso tied to O_mosi), I_speed = 1, write 0xA5 → busy high for exactly 16 cycles; 8 SCK pulses of 1-high/1-low; O_data_in = 0xA5; ready = 1 on the edge busy falls.
- Slave model returns 0x3C, I_speed = 0, FREQ = 48e6, write 0x5A → SCK half-period 60 cycles; 960 busy cycles; slave captures 0x5A MSB first; O_data_in = 0x3C.
- Write 0x11 at I_speed = 3, re-strobe write 0x22 during busy, with the slave model inverting captured bits → only one 48-cycle transfer; O_data_in = 0xEE; the 0x22 strobe is ignored.
- Ready handling, I_speed = 2: I_cmd_read after completion → ready = 0 next cycle. Second transfer with I_cmd_read coincident with the completion edge → ready stays 1 and O_data_in updates.
- Assert I_rst on cycle 20 of a speed-4 transfer → next cycle SCK = 0, MOSI = 1, busy = 0, ready = 0, O_data_in = 0. A later write completes normally.
- Change I_speed from 2 to 7 mid-transfer → the current byte keeps H = 2 (32 cycles); the next byte uses H = 7 (112 cycles).

Source files
------------

// File: rtl/spi_byte_engine_if.sv
// Sequencer-side bundle for the SPI byte engine.
// Carries command strobes, data bytes and the physical SPI pins.
interface spi_byte_engine_if;
  logic       I_cmd_write;
  logic       I_cmd_read;
  logic [3:0] I_speed;
  logic [7:0] I_data_out;
  logic       I_miso;
  logic       O_sck;
  logic       O_mosi;
  logic [7:0] O_data_in;
  logic       O_busy_write;
  logic       O_data_ready;

  modport master (
    output I_cmd_write,
    output I_cmd_read,
    output I_speed,
    output I_data_out,
    output I_miso,
    input  O_sck,
    input  O_mosi,
    input  O_data_in,
    input  O_busy_write,
    input  O_data_ready
  );

  modport slave (
    input  I_cmd_write,
    input  I_cmd_read,
    input  I_speed,
    input  I_data_out,
    input  I_miso,
    output O_sck,
    output O_mosi,
    output O_data_in,
    output O_busy_write,
    output O_data_ready
  );
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 MSB-first SPI master moving one full-duplex byte per write strobe.
// SCK half-period is latched per transfer: slow init rate or 1..15 clocks.
module spi_byte_engine #(
  parameter int FREQ    = 48_000_000,
  parameter int SLOW_HZ = 400_000
) (
  input logic              I_clk,
  input logic              I_rst,
  spi_byte_engine_if.slave bus
);

  localparam int SLOW_RAW = FREQ / (2 * SLOW_HZ);
  localparam int SLOW_H   = (SLOW_RAW < 1) ? 1 : SLOW_RAW;
  localparam int DW       = (SLOW_H > 15) ? $clog2(SLOW_H + 1) : 4;

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hlat_q, hlat_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      phase_q, phase_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      din_q, din_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;
  logic [DW-1:0]   h_sel;

  assign h_sel = (bus.I_speed == 4'd0) ? DW'(SLOW_H)
                                       : DW'(bus.I_speed);

  always_comb begin
    state_d = state_q;
    hlat_d  = hlat_q;
    div_d   = div_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    din_d   = din_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;

    // Completion below overrides this acknowledge on the same edge.
    if (bus.I_cmd_read && rdy_q) begin
      rdy_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.I_cmd_write) begin
          state_d = S_XFER;
          hlat_d  = h_sel;
          div_d   = h_sel - DW'(1);
          phase_d = 4'd0;
          tx_d    = bus.I_data_out;
          rx_d    = 8'd0;
          mosi_d  = bus.I_data_out[7];
          sck_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_XFER: begin
        if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = hlat_q - DW'(1);
          unique case (1'b1)
            !phase_q[0]: begin
              sck_d   = 1'b1;
              rx_d    = {rx_q[6:0], bus.I_miso};
              phase_d = phase_q + 4'd1;
            end
            phase_q == 4'd15: begin
              sck_d   = 1'b0;
              mosi_d  = 1'b1;
              din_d   = rx_q;
              rdy_d   = 1'b1;
              busy_d  = 1'b0;
              phase_d = 4'd0;
              state_d = S_IDLE;
            end
            default: begin
              sck_d   = 1'b0;
              tx_d    = {tx_q[6:0], 1'b0};
              mosi_d  = tx_q[6];
              phase_d = phase_q + 4'd1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      hlat_q  <= '0;
      div_q   <= '0;
      phase_q <= 4'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      din_q   <= 8'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlat_q  <= hlat_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      din_q   <= din_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.O_sck        = sck_q;
  assign bus.O_mosi       = mosi_q;
  assign bus.O_data_in    = din_q;
  assign bus.O_busy_write = busy_q;
  assign bus.O_data_ready = rdy_q;

endmodule
